// File: rtl/frame_buffer_pp.sv
// Ping-pong frame store: the writer fills the back bank while the reader scans the front bank.
// Banks swap only on a reader frame boundary once the writer has completed a frame.
module frame_buffer_pp #(
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned DEPTH      = 153600,
   parameter int unsigned DOUBLE_BUF = 1,
   parameter int unsigned READ_LAT   = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              WriteEn,
   input  logic [ADDR_W-1:0] WriteAdd,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              WriteFrameEnd,
   input  logic              ReadEn,
   input  logic [ADDR_W-1:0] ReadAdd,
   input  logic              ReadFrameStart,
   output logic [DATA_W-1:0] ReadData,
   output logic              ReadValid,
   output logic              WriteBusy,
   output logic              ReadBank,
   output logic [7:0]        FrameCnt,
   output logic [7:0]        DropCnt
);

   localparam int unsigned BANKS  = (DOUBLE_BUF != 0) ? 2 : 1;
   localparam int unsigned NWORDS = BANKS * DEPTH;
   localparam int unsigned PHYS_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              rd_bank_q, rd_bank_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              busy_q, busy_d;

   logic              wr_bank_c;
   logic              wr_in_range_c;
   logic              rd_in_range_c;
   logic              wr_commit_c;
   logic [PHYS_W-1:0] wr_phys_c;
   logic [PHYS_W-1:0] rd_phys_c;

   logic [DATA_W-1:0] mem [NWORDS];

   logic [DATA_W-1:0] rd_data1_q;
   logic              rd_valid1_q;

   // Address decode: bank select plus range check against DEPTH
   always_comb begin
      wr_bank_c     = (DOUBLE_BUF != 0) ? ~rd_bank_q : 1'b0;
      wr_in_range_c = ({1'b0, WriteAdd} < DEPTH_L);
      rd_in_range_c = ({1'b0, ReadAdd} < DEPTH_L);
      wr_phys_c     = wr_bank_c ? (PHYS_W'(DEPTH) + PHYS_W'(WriteAdd)) : PHYS_W'(WriteAdd);
      rd_phys_c     = rd_bank_q ? (PHYS_W'(DEPTH) + PHYS_W'(ReadAdd)) : PHYS_W'(ReadAdd);
   end

   // Swap controller: FILL accepts writes, HOLD keeps a completed frame until vblank
   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      wr_commit_c = 1'b0;
      if (DOUBLE_BUF == 0) begin
         state_d     = ST_FILL;
         wr_commit_c = WriteEn && wr_in_range_c;
      end else begin
         case (state_q)
            ST_FILL: begin
               wr_commit_c = WriteEn && wr_in_range_c;
               if (WriteFrameEnd) begin
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (WriteEn && (drop_cnt_q != 8'hFF)) begin
                  drop_cnt_d = drop_cnt_q + 8'd1;
               end
               if (ReadFrameStart) begin
                  rd_bank_d   = ~rd_bank_q;
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  state_d     = ST_FILL;
               end
            end
            default: state_d = ST_FILL;
         endcase
      end
      busy_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_FILL;
         rd_bank_q   <= 1'b0;
         frame_cnt_q <= 8'd0;
         drop_cnt_q  <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_bank_q   <= rd_bank_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         busy_q      <= busy_d;
      end
   end

   // Pixel storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_commit_c) begin
         mem[wr_phys_c] <= WriteData;
      end
   end

   // First read stage; out-of-range reads return zero but still report valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_valid1_q <= 1'b0;
         rd_data1_q  <= '0;
      end else begin
         rd_valid1_q <= ReadEn;
         if (ReadEn) begin
            rd_data1_q <= rd_in_range_c ? mem[rd_phys_c] : '0;
         end
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] rd_data2_q;
         logic              rd_valid2_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               rd_valid2_q <= 1'b0;
               rd_data2_q  <= '0;
            end else begin
               rd_valid2_q <= rd_valid1_q;
               if (rd_valid1_q) begin
                  rd_data2_q <= rd_data1_q;
               end
            end
         end

         assign ReadData  = rd_data2_q;
         assign ReadValid = rd_valid2_q;
      end else begin : g_lat1
         assign ReadData  = rd_data1_q;
         assign ReadValid = rd_valid1_q;
      end
   endgenerate

   assign WriteBusy = busy_q;
   assign ReadBank  = rd_bank_q;
   assign FrameCnt  = frame_cnt_q;
   assign DropCnt   = drop_cnt_q;

endmodule
